// File: rtl/prime_factorizer.sv
// Trial-division prime factorizer. It accepts one unsigned value and streams its prime
// factors in ascending order. A single W-cycle restoring divider is reused for every trial.
module prime_factorizer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_value,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_factor,
    output logic         out_last,
    output logic         busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        CHECK,
        EMIT
    } state_t;

    state_t        state, state_next;
    logic [W-1:0]  n;          // value still to be factored
    logic [W-1:0]  d;          // current trial divisor
    logic [W-1:0]  q;          // dividend shifting out / quotient shifting in
    logic [W-1:0]  r;          // partial remainder
    logic [CW-1:0] cnt;

    logic          accept;
    logic          small_value;
    logic          div_done;
    logic [W:0]    rem_shift;
    logic [W:0]    rem_sub;
    logic          rem_ge;
    logic          r_zero;
    logic          d_gt_q;

    assign accept      = in_valid && in_ready;
    assign small_value = (in_value < W'(2));
    assign div_done    = (cnt == CW'(W - 1));
    assign rem_shift   = {r, q[W-1]};
    assign rem_ge      = (rem_shift >= {1'b0, d});
    assign rem_sub     = rem_shift - {1'b0, d};
    assign r_zero      = (r == '0);
    // After a non-dividing trial, d > q means d*d > n, so n itself is prime.
    assign d_gt_q      = (d > q);

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == EMIT) && !reset;
    assign busy      = (state != IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: state elements use non-blocking assignments so every register
            // updates from the same pre-edge values, independent of block order.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: assigning the default first keeps every path covered, so no latch is inferred.
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = small_value ? EMIT : DIV;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = (r_zero || d_gt_q) ? EMIT : DIV;
            end
            EMIT: begin
                if (out_ready) begin
                    state_next = out_last ? IDLE : DIV;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n          <= '0;
            d          <= '0;
            q          <= '0;
            r          <= '0;
            cnt        <= '0;
            out_factor <= '0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        n        <= in_value;
                        d        <= W'(2);
                        q        <= in_value;
                        r        <= '0;
                        cnt      <= '0;
                        out_last <= small_value;
                        if (small_value) begin
                            out_factor <= in_value;
                        end
                    end
                end
                DIV: begin
                    cnt <= cnt + CW'(1);
                    r   <= rem_ge ? rem_sub[W-1:0] : rem_shift[W-1:0];
                    q   <= {q[W-2:0], rem_ge};
                end
                CHECK: begin
                    if (r_zero) begin
                        out_factor <= d;
                        out_last   <= (q == W'(1));
                        n          <= q;
                    end else if (d_gt_q) begin
                        out_factor <= n;
                        out_last   <= 1'b1;
                    end else begin
                        d   <= (d == W'(2)) ? W'(3) : d + W'(2);
                        q   <= n;
                        r   <= '0;
                        cnt <= '0;
                    end
                end
                EMIT: begin
                    // Retry the same divisor to catch repeated factors.
                    if (out_ready && !out_last) begin
                        q   <= n;
                        r   <= '0;
                        cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
